// File: rtl/window_fetcher.sv
// window_fetcher: sweeps a FEATURE_WIDTH x FEATURE_HEIGHT window over the image, issuing
// PARALLEL_ROWS-lane row addresses under a credit limit and tagging the returned pixels.
module window_fetcher #(
    parameter int unsigned W_DATA          = 8,
    parameter int unsigned IMG_WIDTH       = 41,
    parameter int unsigned IMG_HEIGHT      = 50,
    parameter int unsigned FEATURE_WIDTH   = 24,
    parameter int unsigned FEATURE_HEIGHT  = 24,
    parameter int unsigned PARALLEL_ROWS   = 1,
    parameter int unsigned STRIDE_X        = 1,
    parameter int unsigned STRIDE_Y        = 1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int unsigned W_X    = $clog2(IMG_WIDTH),
    localparam int unsigned W_Y    = $clog2(IMG_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              addr_valid,
    input  logic                              addr_ready,
    output logic [PARALLEL_ROWS*W_ADDR-1:0]   addr,
    input  logic                              din_valid,
    output logic                              din_ready,
    input  logic [PARALLEL_ROWS*W_DATA-1:0]   din_data,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic [PARALLEL_ROWS*W_DATA-1:0]   dout_data,
    output logic [1:0]                        dout_eot,
    output logic [W_X-1:0]                    dout_win_x,
    output logic [W_Y-1:0]                    dout_win_y
);

    localparam int unsigned W_CR = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [W_Y-1:0] wy;
        logic [W_X-1:0] wx;
        logic [W_Y-1:0] r;
        logic [W_X-1:0] c;
    } pos_t;

    function automatic logic last_c(input pos_t p);
        return 32'(p.c) == FEATURE_WIDTH - 1;
    endfunction

    function automatic logic last_r(input pos_t p);
        return 32'(p.r) == FEATURE_HEIGHT - PARALLEL_ROWS;
    endfunction

    function automatic logic last_wx(input pos_t p);
        return 32'(p.wx) + STRIDE_X + FEATURE_WIDTH > IMG_WIDTH;
    endfunction

    function automatic logic last_wy(input pos_t p);
        return 32'(p.wy) + STRIDE_Y + FEATURE_HEIGHT > IMG_HEIGHT;
    endfunction

    function automatic logic last_all(input pos_t p);
        return last_c(p) && last_r(p) && last_wx(p) && last_wy(p);
    endfunction

    // Column fastest, then row group, then window x, then window y.
    function automatic pos_t next_pos(input pos_t p);
        pos_t n;
        n = p;
        if (!last_c(p)) begin
            n.c = p.c + W_X'(1);
        end else begin
            n.c = '0;
            if (!last_r(p)) begin
                n.r = p.r + W_Y'(PARALLEL_ROWS);
            end else begin
                n.r = '0;
                if (!last_wx(p)) begin
                    n.wx = p.wx + W_X'(STRIDE_X);
                end else begin
                    n.wx = '0;
                    n.wy = last_wy(p) ? '0 : p.wy + W_Y'(STRIDE_Y);
                end
            end
        end
        return n;
    endfunction

    state_t                            state, state_next;
    pos_t                              a_pos, d_pos;
    logic                              a_issued_all;
    logic [W_CR-1:0]                   credit, credit_next;
    logic [PARALLEL_ROWS*W_ADDR-1:0]   next_addr;
    logic                              addr_hs, din_hs, addr_load, start_sweep;

    assign start_sweep = (state == IDLE) && start;
    assign addr_hs     = addr_valid && addr_ready;
    assign din_ready   = busy && (!dout_valid || dout_ready);
    assign din_hs      = din_valid && din_ready;
    assign credit_next = credit + W_CR'(addr_hs) - W_CR'(din_hs);

    // Gating on the post-update credit keeps addr_valid implying credit < MAX_OUTSTANDING.
    assign addr_load = (state == RUN) && !a_issued_all && (!addr_valid || addr_ready)
                       && (32'(credit_next) < MAX_OUTSTANDING);

    always_comb begin
        next_addr = '0;
        for (int unsigned k = 0; k < PARALLEL_ROWS; k++) begin
            next_addr[k*W_ADDR +: W_ADDR] = W_ADDR'((32'(a_pos.wy) + 32'(a_pos.r) + k) * IMG_WIDTH
                                                   + 32'(a_pos.wx) + 32'(a_pos.c));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (addr_hs && a_issued_all) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (credit == '0 && !dout_valid) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit <= '0;
        end else begin
            credit <= credit_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_pos        <= '0;
            a_issued_all <= 1'b0;
            addr_valid   <= 1'b0;
            addr         <= '0;
        end else if (start_sweep) begin
            a_pos        <= '0;
            a_issued_all <= 1'b0;
        end else if (addr_load) begin
            addr         <= next_addr;
            addr_valid   <= 1'b1;
            a_pos        <= next_pos(a_pos);
            a_issued_all <= last_all(a_pos);
        end else if (addr_hs) begin
            addr_valid   <= 1'b0;
        end
    end

    // Data-side position tracks returned beats only, so tags never depend on address timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_pos      <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_eot   <= '0;
            dout_win_x <= '0;
            dout_win_y <= '0;
        end else if (start_sweep) begin
            d_pos      <= '0;
        end else if (din_hs) begin
            d_pos      <= next_pos(d_pos);
            dout_valid <= 1'b1;
            dout_data  <= din_data;
            dout_eot   <= {last_c(d_pos) && last_r(d_pos), last_c(d_pos)};
            dout_win_x <= d_pos.wx;
            dout_win_y <= d_pos.wy;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
